// File: rtl/rpc2_ctrl_axi_pkg.sv
// Shared AXI write-response definitions for the RPC2 controller:
// response codes, accumulator state encoding and the error-merge rule.
package rpc2_ctrl_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  // Writes have no exclusive support, so EXOKAY folds to OKAY. Once it is gone,
  // the remaining codes rank by numeric value (DECERR > SLVERR > OKAY).
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] na;
    logic [1:0] nb;
    na = (a == RESP_EXOKAY) ? RESP_OKAY : a;
    nb = (b == RESP_EXOKAY) ? RESP_OKAY : b;
    return (na > nb) ? na : nb;
  endfunction

endpackage

// File: rtl/rpc2_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO with registered count/full/empty.
// Same-cycle push+pop is allowed when full; when empty the pop is ignored.
module rpc2_ctrl_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [AW:0]      count_next;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) count_next = count + 1'b1;
    else if (pop_ok && !push_ok) count_next = count - 1'b1;
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW + 1)'(DEPTH));
    end
  end

endmodule

// File: rtl/rpc2_ctrl_axi_wr_status_collector.sv
// Merges per-sub-transfer write errors into one BRESP per burst and queues
// the results for the AXI write-response channel.
module rpc2_ctrl_axi_wr_status_collector
  import rpc2_ctrl_axi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_wr_done,
  input  logic        ip_wr_last,
  input  logic [1:0]  ip_wr_error,
  input  logic        bdat_rd_en,
  output logic [1:0]  bdat_dout,
  output logic        bdat_empty,
  output logic        bdat_full,
  output logic [AW:0] bdat_count,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic        acc_busy
);

  acc_state_e state, state_next;
  logic [1:0] acc, acc_next;
  logic [1:0] merged;
  logic       push;
  logic       drop;

  assign merged = resp_merge(acc, ip_wr_error);
  assign push   = ip_wr_done & ip_wr_last;
  // The engine cannot be stalled: a burst finishing into a full FIFO with no
  // concurrent pop loses its status and is recorded only in overflow.
  assign drop   = push & bdat_full & ~bdat_rd_en;

  always_comb begin
    state_next = state;
    acc_next   = acc;
    if (ip_wr_done) begin
      if (ip_wr_last) begin
        state_next = ACC_IDLE;
        acc_next   = RESP_OKAY;
      end else begin
        state_next = ACC_ACCUM;
        acc_next   = merged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ACC_IDLE;
      acc      <= RESP_OKAY;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      if (drop) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign acc_busy = (state == ACC_ACCUM);

  rpc2_ctrl_sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2)
  ) u_bresp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (merged),
    .pop   (bdat_rd_en),
    .dout  (bdat_dout),
    .empty (bdat_empty),
    .full  (bdat_full),
    .count (bdat_count)
  );

endmodule

// File: tb/tb_rpc2_ctrl_axi_wr_status_collector.sv
// Scoreboard bench: driver pushes expected BRESPs from a burst-level model,
// a negedge monitor checks flags every cycle and pops on each DUT read.
module tb_rpc2_ctrl_axi_wr_status_collector;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        ip_wr_done;
  logic        ip_wr_last;
  logic [1:0]  ip_wr_error;
  logic        bdat_rd_en;
  logic [1:0]  bdat_dout;
  logic        bdat_empty;
  logic        bdat_full;
  logic [AW:0] bdat_count;
  logic        overflow;
  logic        overflow_clr;
  logic        acc_busy;

  rpc2_ctrl_axi_wr_status_collector #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .ip_wr_done   (ip_wr_done),
    .ip_wr_last   (ip_wr_last),
    .ip_wr_error  (ip_wr_error),
    .bdat_rd_en   (bdat_rd_en),
    .bdat_dout    (bdat_dout),
    .bdat_empty   (bdat_empty),
    .bdat_full    (bdat_full),
    .bdat_count   (bdat_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .acc_busy     (acc_busy)
  );

  always #5 clk = ~clk;

  // Scoreboard / reference model state
  logic [1:0] exp_q[$];
  logic [1:0] part_q[$];
  bit         ovf_m;
  int         cur_count;
  bit         cur_ovf;
  bit         cur_busy;
  bit         chk_en;
  int         n_cmp;
  int         n_bad;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Burst response = worst severity among its sub-transfers; EXOKAY counts as OKAY.
  function automatic logic [1:0] ref_bresp(input logic [1:0] errs[$]);
    int worst;
    worst = 0;
    foreach (errs[i]) begin
      int rank;
      case (errs[i])
        2'b11:   rank = 2;
        2'b10:   rank = 1;
        default: rank = 0;
      endcase
      if (rank > worst) worst = rank;
    end
    case (worst)
      2:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive(input bit d, input bit l, input logic [1:0] e, input bit rd, input bit clr);
    bit drop;
    @(posedge clk);
    #1;
    cur_count = exp_q.size();
    cur_ovf   = ovf_m;
    cur_busy  = (part_q.size() > 0);
    ip_wr_done   = d;
    ip_wr_last   = l;
    ip_wr_error  = e;
    bdat_rd_en   = rd;
    overflow_clr = clr;
    drop = 1'b0;
    if (d) begin
      part_q.push_back(e);
      if (l) begin
        logic [1:0] r;
        r = ref_bresp(part_q);
        part_q.delete();
        if (exp_q.size() < DEPTH || rd) exp_q.push_back(r);
        else drop = 1'b1;
      end
    end
    if (drop) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'b00, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    reset  = 1'b1;
    ip_wr_done = 0; ip_wr_last = 0; ip_wr_error = 0; bdat_rd_en = 0; overflow_clr = 0;
    exp_q.delete();
    part_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_empty", bdat_empty, 1);
    chk("rst_full", bdat_full, 0);
    chk("rst_count", bdat_count, 0);
    chk("rst_dout", bdat_dout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_acc_busy", acc_busy, 0);
    reset = 1'b0;
  endtask

  // Monitor: flags every cycle, head value while non-empty, pop on read.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && chk_en) begin
        chk("count", bdat_count, cur_count);
        chk("empty", bdat_empty, cur_count == 0);
        chk("full", bdat_full, cur_count == DEPTH);
        chk("overflow", overflow, cur_ovf);
        chk("acc_busy", acc_busy, cur_busy);
        if (!bdat_empty) begin
          if (exp_q.size() == 0) begin
            chk("head_unexpected", 1, 0);
          end else begin
            chk("dout", bdat_dout, exp_q[0]);
            if (bdat_rd_en) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 0; ovf_m = 0;
    cur_count = 0; cur_ovf = 0; cur_busy = 0;
    reset = 1'b1;
    ip_wr_done = 0; ip_wr_last = 0; ip_wr_error = 0; bdat_rd_en = 0; overflow_clr = 0;
    #1;
    chk("async_rst_empty", bdat_empty, 1);
    do_reset();

    // 1: single burst, then read
    drive(1, 1, 2'b00, 0, 0);
    idle(1);
    drive(0, 0, 2'b00, 1, 0);
    idle(1);

    // 2: merged bursts
    drive(1, 0, 2'b10, 0, 0);
    drive(1, 0, 2'b00, 0, 0);
    drive(1, 1, 2'b00, 0, 0);
    drive(1, 0, 2'b01, 0, 0);
    drive(1, 1, 2'b11, 0, 0);
    drive(1, 1, 2'b01, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) drive(0, 0, 2'b00, 1, 0);
    idle(1);

    // 3: fill, overflow, clear
    drive(1, 1, 2'b10, 0, 0);
    drive(1, 1, 2'b00, 0, 0);
    drive(1, 1, 2'b11, 0, 0);
    drive(1, 1, 2'b00, 0, 0);
    drive(1, 1, 2'b11, 0, 0);
    idle(1);
    drive(0, 0, 2'b00, 0, 1);
    // clear colliding with a new drop keeps overflow set
    drive(1, 1, 2'b10, 0, 1);
    drive(0, 0, 2'b00, 0, 1);

    // 4: full push+pop, drain across wrap
    drive(1, 1, 2'b11, 1, 0);
    drive(1, 1, 2'b10, 1, 0);
    idle(1);
    for (int i = 0; i < 5; i++) drive(0, 0, 2'b00, 1, 0);

    // 5: empty pop, then push+pop on empty
    drive(0, 0, 2'b00, 1, 0);
    drive(1, 1, 2'b10, 1, 0);
    idle(1);
    drive(0, 0, 2'b00, 1, 0);
    idle(1);

    // 6: reset mid-accumulation with queued entries
    drive(1, 1, 2'b11, 0, 0);
    drive(1, 1, 2'b10, 0, 0);
    drive(1, 0, 2'b11, 0, 0);
    idle(1);
    do_reset();
    drive(1, 1, 2'b00, 0, 0);
    idle(1);
    drive(0, 0, 2'b00, 1, 0);
    idle(1);

    // Random: slow reader (overflow-prone), then fast reader
    for (int i = 0; i < 600; i++) begin
      bit d;
      d = ($urandom_range(0, 2) != 0);
      drive(d, d && ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
            (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 2'b00, 1, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
